// File: rtl/stream_capture_to_bram.sv
// Captures a window of AXI-stream beats into a BRAM write port once armed (immediate or orbit-synchronous trigger).
// Latency: accepted beat reaches the BRAM port one cycle later; trigger costs one ARMED cycle or waits for an orbit edge.
// Backpressure: none; TREADY only drops during reset and beats outside the capture window are discarded.
module stream_capture_to_bram #(
    parameter int unsigned MEM_DEPTH = 2048
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [31:0] data_stream_TDATA,
    input  logic        data_stream_TVALID,
    output logic        data_stream_TREADY,
    input  logic        fc_orbitSync,
    input  logic        arm,
    input  logic        abort,
    input  logic [1:0]  trig_mode,
    input  logic [15:0] capture_len,
    output logic        bram_CLK,
    output logic        bram_RST,
    output logic        bram_EN,
    output logic [3:0]  bram_WE,
    output logic [31:0] bram_ADDR,
    output logic [31:0] bram_DIN,
    output logic        busy,
    output logic        done,
    output logic [15:0] words_captured
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // 17 bits so a full 65536-word window can be represented
    localparam logic [16:0] DEPTH = 17'(MEM_DEPTH);
    localparam logic [1:0]  MODE_ORBIT = 2'd1;

    state_t      state_q;
    logic [1:0]  mode_q;
    logic [16:0] len_q;
    logic [16:0] cnt_q;
    logic        orbit_q;
    logic        en_q;
    logic [31:0] addr_q;
    logic [31:0] din_q;
    logic        busy_q;
    logic        done_q;

    logic [16:0] len_d;
    logic [16:0] cnt_d;
    logic        orbit_rise;

    // Effective length clamp, incremented word count and orbit rising-edge detect
    always_comb begin
        len_d = {1'b0, capture_len};
        if (capture_len == 16'd0 || len_d > DEPTH) begin
            len_d = DEPTH;
        end
        cnt_d      = cnt_q + 17'd1;
        orbit_rise = fc_orbitSync & ~orbit_q;
    end

    // Capture FSM with registered BRAM write port and status outputs
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
            mode_q  <= 2'd0;
            len_q   <= 17'd0;
            cnt_q   <= 17'd0;
            orbit_q <= 1'b0;
            en_q    <= 1'b0;
            addr_q  <= 32'd0;
            din_q   <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // Sync level is sampled every cycle so the edge detector is primed on entering ARMED
            orbit_q <= fc_orbitSync;
            en_q    <= 1'b0;
            if (abort) begin
                // Abort wins over arm and drops this cycle's beat; the count is kept for readback
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (arm) begin
                            state_q <= ST_ARMED;
                            mode_q  <= trig_mode;
                            len_q   <= len_d;
                            cnt_q   <= 17'd0;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                    ST_ARMED: begin
                        // The beat in the trigger cycle itself is never captured
                        if (mode_q != MODE_ORBIT || orbit_rise) begin
                            state_q <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        if (data_stream_TVALID) begin
                            en_q   <= 1'b1;
                            addr_q <= {14'd0, cnt_q[15:0], 2'b00};
                            din_q  <= data_stream_TDATA;
                            cnt_q  <= cnt_d;
                            if (cnt_d == len_q) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign data_stream_TREADY = ~areset;
    assign bram_CLK           = clk;
    assign bram_RST           = areset;
    assign bram_EN            = en_q;
    assign bram_WE            = {4{en_q}};
    assign bram_ADDR          = addr_q;
    assign bram_DIN           = din_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign words_captured     = cnt_q[15:0];

endmodule

// File: doc/stream_capture_to_bram.md
STREAM_CAPTURE_TO_BRAM -- requirements
Module: stream_capture_to_bram

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 2048: capture BRAM depth in 32-bit words, a power of two, at most 65536.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all logic rising-edge.
REQ-003 SHALL have port areset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port data_stream_TDATA, input, 32 bits: AXI-stream payload from the pattern/link source.
REQ-005 SHALL have port data_stream_TVALID, input, 1 bit: payload valid.
REQ-006 SHALL have port data_stream_TREADY, output, 1 bit: sink ready.
REQ-007 SHALL have port fc_orbitSync, input, 1 bit: fast-command orbit sync level.
REQ-008 SHALL have port arm, input, 1 bit: single-cycle capture request.
REQ-009 SHALL have port abort, input, 1 bit: single-cycle cancel.
REQ-010 SHALL have port trig_mode, input, 2 bits: 0 = immediate, 1 = orbit-synchronous, 2 and 3 = immediate.
REQ-011 SHALL have port capture_len, input, 16 bits: words to capture.
REQ-012 SHALL have ports bram_CLK, bram_RST, bram_EN (outputs, 1 bit each), bram_WE (output, 4 bits), bram_ADDR and bram_DIN (outputs, 32 bits each): BRAM write port.
REQ-013 SHALL have ports busy and done (outputs, 1 bit each) and words_captured (output, 16 bits): status.

Function
REQ-014 SHALL drive data_stream_TREADY = !areset; beats are never back-pressured, and beats outside CAPTURE are discarded.
REQ-015 SHALL implement states IDLE, ARMED, CAPTURE and DONE.
REQ-016 SHALL, on arm in IDLE or DONE, enter ARMED next cycle, latch trig_mode and the effective length, and clear words_captured and done.
REQ-017 SHALL compute effective length: capture_len = 0 or capture_len > MEM_DEPTH gives MEM_DEPTH; otherwise capture_len.
REQ-018 SHALL ignore arm while in ARMED or CAPTURE.
REQ-019 SHALL, in ARMED with latched mode other than 1, enter CAPTURE on the next cycle.
REQ-020 SHALL, in ARMED with latched mode 1, register fc_orbitSync each cycle and enter CAPTURE on the cycle after a rising edge (fc_orbitSync = 1 and the registered value = 0).
REQ-021 SHALL, in ARMED, not capture the beat present in the trigger cycle.
REQ-022 SHALL, for each beat with TVALID = 1 in CAPTURE, write TDATA at word address words_captured and then increment words_captured.
REQ-023 SHALL register the BRAM write by one cycle: a beat accepted in cycle t gives, in cycle t+1, bram_EN = 1, bram_WE = 4'hF, bram_ADDR = {words_captured, 2'b00} zero-extended, and bram_DIN = TDATA.
REQ-024 SHALL otherwise drive bram_EN = 0, bram_WE = 0, and hold bram_ADDR and bram_DIN.
REQ-025 SHALL enter DONE on the cycle after the beat that makes words_captured equal the effective length.
REQ-026 SHALL hold DONE until arm or abort arrives.
REQ-027 SHALL assert busy in ARMED and CAPTURE, and assert done only in DONE.
REQ-028 SHALL, on abort in any state, enter IDLE next cycle and keep words_captured.
REQ-029 SHALL suppress any write pending from the abort cycle's beat.
REQ-030 SHALL give abort priority over arm when both are asserted in the same cycle.
REQ-031 SHALL drive bram_CLK = clk and bram_RST = areset.

Reset
REQ-032 SHALL, while areset = 1, force state IDLE, words_captured = 0, busy = 0, done = 0, bram_EN = 0, bram_WE = 0, bram_ADDR = 0, bram_DIN = 0, the registered orbit sync = 0 and TREADY = 0.
REQ-033 SHALL, when areset asserts mid-capture, abandon the capture with no further writes.

Verification
REQ-034 Mode 0, len 4, continuous beats 0xA0..0xA7 after arm -> four writes, addresses 0x0, 0x4, 0x8, 0xC, data 0xA0..0xA3 (the first beats in CAPTURE); done = 1; words_captured = 4.
REQ-035 Mode 1, arm, orbit rising edge at cycle t, beats every cycle -> first write carries the cycle t+1 beat at address 0.
REQ-036 Mode 0, len 3, TVALID toggling 1-0-1-0-1 -> exactly 3 writes to consecutive addresses; no write in TVALID = 0 cycles.
REQ-037 len 0 and len 5000 with MEM_DEPTH 2048 -> 2048 writes each, last bram_ADDR = 0x1FFC.
REQ-038 abort and arm in the same cycle during CAPTURE after 2 words -> IDLE, words_captured = 2, no further writes.
REQ-039 areset pulse mid-capture -> all outputs zero during reset, IDLE after release, arm works normally.
